// File: rtl/two_pass_labeling.sv
// two_pass_labeling
//   Streaming 4-connected component labeler for a binarised frame.
//   Pass 1 (while href is high) labels foreground pixels, records label
//   equivalences in a parent table and accumulates per-label area and
//   bounding box. Pass 2 (after vsync falls) resolves every label to its
//   root, folds statistics into the roots and emits one record per object.
// Ports:
//   clk, rst_n          clock, synchronous active-high reset
//   per_frame_*         incoming video timing and 8-bit pixel
//   post_frame_*        timing passthrough, 1-clk latency
//   merged_*            object record stream and end-of-frame pulse
//   label_overflow      sticky per frame, label table ran out
module two_pass_labeling #(
  parameter  int IMG_HDISP          = 640,
  parameter  int IMG_VDISP          = 480,
  parameter  int MAX_LABELS         = 50,
  parameter  int MAX_AREA           = 2500,
  parameter  int MAX_PERIMETER_CALC = 1024,
  parameter  int ADDR_WIDTH         = 8,
  parameter  int LABEL_INF_WIDTH    = 32,
  localparam int AREA_W  = $clog2(MAX_AREA + 1),
  localparam int PERIM_W = $clog2(MAX_PERIMETER_CALC + 1),
  localparam int HALF_W  = LABEL_INF_WIDTH / 2,
  localparam int XW      = $clog2(IMG_HDISP + 1),
  localparam int YW      = $clog2(IMG_VDISP + 1),
  localparam int LW      = $clog2(MAX_LABELS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       per_frame_vsync,
  input  logic                       per_frame_href,
  input  logic [7:0]                 per_img_Y,
  output logic                       post_frame_vsync,
  output logic                       post_frame_href,
  output logic                       merged_valid,
  output logic [ADDR_WIDTH-1:0]      merged_label,
  output logic [AREA_W-1:0]          merged_area,
  output logic [PERIM_W-1:0]         merged_perimeter,
  output logic [LABEL_INF_WIDTH-1:0] merged_pos,
  output logic                       merged_done,
  output logic                       label_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_RESOLVE, S_EMIT, S_DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LBL_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LBL_FULL = ADDR_WIDTH'(MAX_LABELS);
  localparam logic [AREA_W-1:0]     AREA_MAX = AREA_W'(MAX_AREA);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    vsync_q, href_q;
  logic [XW-1:0]           x_q;
  logic [YW-1:0]           y_q;
  logic [ADDR_WIDTH-1:0]   prev_label_q, next_label_q;
  logic [ADDR_WIDTH-1:0]   line_buf_q [IMG_HDISP];
  logic [ADDR_WIDTH-1:0]   parent_q   [MAX_LABELS];
  logic [AREA_W-1:0]       area_q     [MAX_LABELS];
  logic [XW-1:0]           xmin_q [MAX_LABELS], xmax_q [MAX_LABELS];
  logic [YW-1:0]           ymin_q [MAX_LABELS], ymax_q [MAX_LABELS];
  logic                    valid_q, done_q, ovf_q;
  logic [ADDR_WIDTH-1:0]   label_q;
  logic [AREA_W-1:0]       area_out_q;
  logic [PERIM_W-1:0]      perim_q;
  logic [LABEL_INF_WIDTH-1:0] pos_q;

  logic                    vs_rise_s, vs_fall_s, href_fall_s, pix_en_s, fg_s;
  logic [ADDR_WIDTH-1:0]   l_s, u_s, lo_s, hi_s, p_s, pmin_s, pmax_s, cur_label_s;
  logic                    new_s, ovf_s, merge_s, second_s;
  logic [LW-1:0]           ia_s, ra_s, ca_s;
  logic [ADDR_WIDTH-1:0]   par_i_s, root_s;
  logic [AREA_W:0]         area_sum_s;
  logic                    idx_live_s;
  logic [XW:0]             w_s, xsum_s;
  logic [YW:0]             h_s, ysum_s;
  logic [31:0]             perim_full_s;
  logic [PERIM_W-1:0]      perim_s;

  assign post_frame_vsync = vsync_q;
  assign post_frame_href  = href_q;
  assign merged_valid     = valid_q;
  assign merged_label     = label_q;
  assign merged_area      = area_out_q;
  assign merged_perimeter = perim_q;
  assign merged_pos       = pos_q;
  assign merged_done      = done_q;
  assign label_overflow   = ovf_q;

  // Pass-1 neighbour lookup, label choice and equivalence update terms.
  always_comb begin
    vs_rise_s   = per_frame_vsync & ~vsync_q;
    vs_fall_s   = ~per_frame_vsync & vsync_q;
    href_fall_s = ~per_frame_href & href_q;
    pix_en_s    = (state_q == S_IDLE) && per_frame_href && !vs_rise_s;
    fg_s        = (per_img_Y >= 8'd128);
    l_s         = (x_q == '0) ? '0 : prev_label_q;
    if ((y_q != '0) && (x_q < XW'(IMG_HDISP))) begin
      u_s = line_buf_q[x_q];
    end else begin
      u_s = '0;
    end
    lo_s        = (l_s < u_s) ? l_s : u_s;
    hi_s        = (l_s < u_s) ? u_s : l_s;
    p_s         = parent_q[LW'(hi_s)];
    pmin_s      = (p_s < lo_s) ? p_s : lo_s;
    pmax_s      = (p_s < lo_s) ? lo_s : p_s;
    new_s       = 1'b0;
    ovf_s       = 1'b0;
    cur_label_s = '0;
    if (!fg_s) begin
      cur_label_s = '0;
    end else if ((l_s == '0) && (u_s == '0)) begin
      if (next_label_q == LBL_FULL) begin
        ovf_s = 1'b1;
      end else begin
        cur_label_s = next_label_q;
        new_s       = 1'b1;
      end
    end else if (l_s == '0) begin
      cur_label_s = u_s;
    end else if (u_s == '0) begin
      cur_label_s = l_s;
    end else begin
      cur_label_s = lo_s;
    end
    merge_s  = fg_s && (l_s != '0) && (u_s != '0) && (l_s != u_s);
    // A parent that is neither hi nor lo carries a second equivalence.
    second_s = merge_s && (p_s != hi_s) && (p_s != lo_s);
    ca_s     = LW'(cur_label_s);
  end

  // Pass-2 root lookup, stat folding and record formatting terms.
  always_comb begin
    ia_s       = LW'(idx_q);
    idx_live_s = (idx_q < next_label_q);
    par_i_s    = parent_q[ia_s];
    // Lower labels are already resolved, so one indirection reaches the root.
    root_s     = (par_i_s == idx_q) ? idx_q : parent_q[LW'(par_i_s)];
    ra_s       = LW'(root_s);
    area_sum_s = {1'b0, area_q[ra_s]} + {1'b0, area_q[ia_s]};
    w_s        = {1'b0, xmax_q[ia_s]} - {1'b0, xmin_q[ia_s]} + {{XW{1'b0}}, 1'b1};
    h_s        = {1'b0, ymax_q[ia_s]} - {1'b0, ymin_q[ia_s]} + {{YW{1'b0}}, 1'b1};
    xsum_s     = {1'b0, xmin_q[ia_s]} + {1'b0, xmax_q[ia_s]};
    ysum_s     = {1'b0, ymin_q[ia_s]} + {1'b0, ymax_q[ia_s]};
    perim_full_s = (32'(w_s) + 32'(h_s)) << 1;
    if (perim_full_s > 32'(MAX_PERIMETER_CALC)) begin
      perim_s = PERIM_W'(MAX_PERIMETER_CALC);
    end else begin
      perim_s = PERIM_W'(perim_full_s);
    end
  end

  // Pass-2 sequencing: resolve labels, emit roots, pulse done.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (vs_fall_s) begin
          state_d = S_RESOLVE;
          idx_d   = LBL_ONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESOLVE: begin
        if (!idx_live_s) begin
          state_d = S_EMIT;
          idx_d   = LBL_ONE;
        end else begin
          idx_d = idx_q + LBL_ONE;
        end
      end
      S_EMIT: begin
        if (!idx_live_s) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + LBL_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A new frame abandons any pass-2 work in progress.
    if (vs_rise_s) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // FSM state and label index registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Line buffer of the previous line's labels; rows at y=0 never read it.
  always_ff @(posedge clk) begin
    if (pix_en_s && (x_q < XW'(IMG_HDISP))) begin
      line_buf_q[x_q] <= cur_label_s;
    end
  end

  // Timing passthrough, coordinates, label tables and record outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      vsync_q <= 1'b0; href_q <= 1'b0;
      x_q <= '0; y_q <= '0;
      prev_label_q <= '0; next_label_q <= LBL_ONE;
      valid_q <= 1'b0; done_q <= 1'b0; ovf_q <= 1'b0;
      label_q <= '0; area_out_q <= '0; perim_q <= '0; pos_q <= '0;
      for (int i = 0; i < MAX_LABELS; i++) begin
        parent_q[i] <= ADDR_WIDTH'(i); area_q[i] <= '0;
        xmin_q[i] <= '1; xmax_q[i] <= '0; ymin_q[i] <= '1; ymax_q[i] <= '0;
      end
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      valid_q <= 1'b0;
      done_q  <= (state_q == S_DONE) && !vs_rise_s;
      if (vs_rise_s) begin
        x_q <= '0; y_q <= '0;
      end else if (per_frame_href) begin
        x_q <= x_q + {{(XW-1){1'b0}}, 1'b1};
      end else if (href_fall_s) begin
        x_q <= '0; y_q <= y_q + {{(YW-1){1'b0}}, 1'b1};
      end
      if (vs_rise_s) begin
        next_label_q <= LBL_ONE; ovf_q <= 1'b0;
        for (int i = 0; i < MAX_LABELS; i++) begin
          parent_q[i] <= ADDR_WIDTH'(i); area_q[i] <= '0;
          xmin_q[i] <= '1; xmax_q[i] <= '0; ymin_q[i] <= '1; ymax_q[i] <= '0;
        end
      end else if (pix_en_s) begin
        prev_label_q <= cur_label_s;
        if (new_s) next_label_q <= next_label_q + LBL_ONE;
        if (ovf_s) ovf_q <= 1'b1;
        if (cur_label_s != '0) begin
          area_q[ca_s] <= (area_q[ca_s] == AREA_MAX) ? AREA_MAX
                          : area_q[ca_s] + {{(AREA_W-1){1'b0}}, 1'b1};
          if (x_q < xmin_q[ca_s]) xmin_q[ca_s] <= x_q;
          if (x_q > xmax_q[ca_s]) xmax_q[ca_s] <= x_q;
          if (y_q < ymin_q[ca_s]) ymin_q[ca_s] <= y_q;
          if (y_q > ymax_q[ca_s]) ymax_q[ca_s] <= y_q;
        end
        if (merge_s) begin
          parent_q[LW'(hi_s)] <= pmin_s;
          if (second_s) parent_q[LW'(pmax_s)] <= pmin_s;
        end
      end else if ((state_q == S_RESOLVE) && idx_live_s) begin
        parent_q[ia_s] <= root_s;
        if (root_s != idx_q) begin
          area_q[ra_s] <= (area_sum_s > {1'b0, AREA_MAX}) ? AREA_MAX : AREA_W'(area_sum_s);
          if (xmin_q[ia_s] < xmin_q[ra_s]) xmin_q[ra_s] <= xmin_q[ia_s];
          if (xmax_q[ia_s] > xmax_q[ra_s]) xmax_q[ra_s] <= xmax_q[ia_s];
          if (ymin_q[ia_s] < ymin_q[ra_s]) ymin_q[ra_s] <= ymin_q[ia_s];
          if (ymax_q[ia_s] > ymax_q[ra_s]) ymax_q[ra_s] <= ymax_q[ia_s];
        end
      end else if ((state_q == S_EMIT) && idx_live_s && (par_i_s == idx_q)
                   && (area_q[ia_s] != '0)) begin
        valid_q    <= 1'b1;
        label_q    <= idx_q;
        area_out_q <= area_q[ia_s];
        perim_q    <= perim_s;
        pos_q      <= {HALF_W'(xsum_s >> 1), HALF_W'(ysum_s >> 1)};
      end
    end
  end

endmodule

// File: tb/tb_two_pass_labeling.sv
// tb_two_pass_labeling
//   Directed frames with hand-computed object records: empty frame, a
//   10x10 square, a U-shape that needs a label merge, 60 isolated pixels
//   overflowing the label table, a saturating 60x60 square, repeated
//   frames and a mid-frame reset.
module tb_two_pass_labeling;

  logic        clk = 1'b0;
  logic        rst_n, per_frame_vsync, per_frame_href;
  logic [7:0]  per_img_Y;
  logic        post_frame_vsync, post_frame_href, merged_valid, merged_done, label_overflow;
  logic [7:0]  merged_label;
  logic [11:0] merged_area;
  logic [10:0] merged_perimeter;
  logic [31:0] merged_pos;

  int n_checks = 0;
  int n_fails  = 0;
  int done_cnt = 0;
  logic mon_en = 1'b0;
  logic vs_exp = 1'b0;
  logic hr_exp = 1'b0;
  int q_label[$], q_area[$], q_perim[$];
  logic [31:0] q_pos[$];

  always #5 clk = ~clk;

  two_pass_labeling dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href), .per_img_Y(per_img_Y),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .merged_valid(merged_valid), .merged_label(merged_label), .merged_area(merged_area),
    .merged_perimeter(merged_perimeter), .merged_pos(merged_pos),
    .merged_done(merged_done), .label_overflow(label_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference 1-clk delay of the timing inputs (cleared by reset).
  always @(posedge clk) begin
    vs_exp <= rst_n ? 1'b0 : per_frame_vsync;
    hr_exp <= rst_n ? 1'b0 : per_frame_href;
  end

  // Monitor: passthrough check and record/done collection.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("post_vsync", {63'd0, post_frame_vsync}, {63'd0, vs_exp});
      chk("post_href",  {63'd0, post_frame_href},  {63'd0, hr_exp});
    end
    if (merged_valid === 1'b1) begin
      q_label.push_back(int'(merged_label));
      q_area.push_back(int'(merged_area));
      q_perim.push_back(int'(merged_perimeter));
      q_pos.push_back(merged_pos);
    end
    if (merged_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic logic [7:0] pix(input int shape, input int x, input int y);
    logic fg;
    case (shape)
      1:       fg = (x >= 20 && x <= 29 && y >= 5 && y <= 14);
      2:       fg = (x >= 2 && x <= 4 && y >= 2 && y <= 12) ||
                    (x >= 10 && x <= 12 && y >= 2 && y <= 12) ||
                    (x >= 2 && x <= 12 && y >= 11 && y <= 12);
      3:       fg = (x % 2 == 0) && (y % 2 == 0);
      4:       fg = (x >= 2 && x <= 61 && y >= 1 && y <= 60);
      default: fg = 1'b0;
    endcase
    if (fg) return ((x + y) % 2 == 1) ? 8'd128 : 8'd255;
    else    return (x % 2 == 1) ? 8'd127 : 8'd0;
  endfunction

  // Drives one frame; abort_line >= 0 asserts reset at the start of that line.
  task automatic send_frame(input int w, input int h, input int shape, input int abort_line);
    per_frame_vsync = 1'b1; per_frame_href = 1'b0; per_img_Y = 8'd0;
    repeat (3) @(negedge clk);
    for (int y = 0; y < h; y++) begin
      if (y == abort_line) begin
        rst_n = 1'b1; per_frame_vsync = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        return;
      end
      for (int x = 0; x < w; x++) begin
        per_frame_href = 1'b1; per_img_Y = pix(shape, x, y);
        @(negedge clk);
      end
      per_frame_href = 1'b0; per_img_Y = 8'd0;
      repeat (4) @(negedge clk);
    end
    per_frame_vsync = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int shape,
                           output int base, output int nrec, output int ndone);
    int d0;
    base = q_label.size();
    d0   = done_cnt;
    send_frame(w, h, shape, -1);
    for (int c = 0; c < 150 && done_cnt == d0; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    nrec  = q_label.size() - base;
    ndone = done_cnt - d0;
  endtask

  task automatic check_rec(input string tag, input int k, input int lbl, input int area,
                           input int perim, input int cx, input int cy);
    logic [31:0] pos_exp;
    pos_exp = (32'(cx) << 16) | 32'(cy);
    if (k < q_label.size()) begin
      chk({tag, "_label"}, 64'(q_label[k]), 64'(lbl));
      chk({tag, "_area"},  64'(q_area[k]),  64'(area));
      chk({tag, "_perim"}, 64'(q_perim[k]), 64'(perim));
      chk({tag, "_pos"},   64'(q_pos[k]),   64'(pos_exp));
    end else begin
      chk({tag, "_missing"}, 64'(q_label.size()), 64'(k + 1));
    end
  endtask

  initial begin
    int base, nrec, ndone, k;
    rst_n = 1'b1; per_frame_vsync = 1'b1; per_frame_href = 1'b1; per_img_Y = 8'd255;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_valid", 64'(merged_valid), 64'd0);
    chk("rst_done",  64'(merged_done), 64'd0);
    chk("rst_ovf",   64'(label_overflow), 64'd0);
    chk("rst_label", 64'(merged_label), 64'd0);
    chk("rst_area",  64'(merged_area), 64'd0);
    chk("rst_perim", 64'(merged_perimeter), 64'd0);
    chk("rst_pos",   64'(merged_pos), 64'd0);
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_img_Y = 8'd0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Empty frame: no records, one done pulse.
    run_frame(64, 32, 0, base, nrec, ndone);
    chk("empty_nrec", 64'(nrec), 64'd0);
    chk("empty_done", 64'(ndone), 64'd1);

    // 10x10 square.
    run_frame(40, 20, 1, base, nrec, ndone);
    chk("sq_nrec", 64'(nrec), 64'd1);
    chk("sq_done", 64'(ndone), 64'd1);
    check_rec("sq", base, 1, 100, 40, 24, 9);
    chk("sq_ovf", 64'(label_overflow), 64'd0);

    // U-shape: labels 1 and 2 merge into 1.
    run_frame(40, 20, 2, base, nrec, ndone);
    chk("u_nrec", 64'(nrec), 64'd1);
    chk("u_done", 64'(ndone), 64'd1);
    check_rec("u", base, 1, 76, 44, 7, 7);

    // 60 isolated pixels: labels 1..49, then overflow.
    run_frame(40, 6, 3, base, nrec, ndone);
    chk("grid_nrec", 64'(nrec), 64'd49);
    chk("grid_done", 64'(ndone), 64'd1);
    chk("grid_ovf", 64'(label_overflow), 64'd1);
    for (int i = 1; i <= 49; i++) begin
      k = i - 1;
      check_rec("grid", base + k, i, 1, 4, (k % 20) * 2, (k / 20) * 2);
    end

    // Idle reset clears the sticky overflow.
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_ovf", 64'(label_overflow), 64'd0);

    // 60x60 square: area saturates.
    run_frame(64, 62, 4, base, nrec, ndone);
    chk("big_nrec", 64'(nrec), 64'd1);
    check_rec("big", base, 1, 2500, 240, 31, 30);

    // Same frame 12 times.
    for (int f = 0; f < 12; f++) begin
      repeat (200) @(negedge clk);
      run_frame(40, 20, 1, base, nrec, ndone);
      chk("rep_nrec", 64'(nrec), 64'd1);
      chk("rep_done", 64'(ndone), 64'd1);
      check_rec("rep", base, 1, 100, 40, 24, 9);
    end

    // Reset in the middle of a U frame, then resend it.
    base = q_label.size();
    k    = done_cnt;
    send_frame(40, 20, 2, 6);
    chk("abort_valid", 64'(merged_valid), 64'd0);
    chk("abort_done",  64'(merged_done), 64'd0);
    chk("abort_label", 64'(merged_label), 64'd0);
    chk("abort_area",  64'(merged_area), 64'd0);
    repeat (150) @(negedge clk);
    chk("abort_nrec",  64'(q_label.size() - base), 64'd0);
    chk("abort_ndone", 64'(done_cnt - k), 64'd0);
    run_frame(40, 20, 2, base, nrec, ndone);
    chk("u2_nrec", 64'(nrec), 64'd1);
    chk("u2_done", 64'(ndone), 64'd1);
    check_rec("u2", base, 1, 76, 44, 7, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
